// File: rtl/outport_uart_tx_pkg.sv
// Shared types and defaults for the CPU output-port UART path.
package cpu_io_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 4;
  localparam int DEFAULT_DEPTH        = 4;

  function automatic int bytes_per_word(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/outport_uart_tx_fifo.sv
// Show-ahead word FIFO between the CPU outport and the UART serialiser.
module outport_fifo import cpu_io_pkg::*; #(
  parameter int n     = 32,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [n-1:0] din,
  output logic [n-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [n-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic          full_reg, empty_reg;
  logic          push_ok, pop_ok;

  // A write against a full FIFO is refused even if a pop frees a slot on the same edge.
  assign push_ok = push & ~full_reg;
  assign pop_ok  = pop & ~empty_reg;

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      full_reg  <= (count_next == CW'(DEPTH));
      empty_reg <= (count_next == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr_reg] <= din;
  end

  assign dout  = mem[rd_ptr_reg];
  assign full  = full_reg;
  assign empty = empty_reg;

endmodule

// File: rtl/outport_uart_tx.sv
// Buffers CPU outport words and sends them LSB-byte-first as UART 8N1 frames on tx.
module outport_uart_tx import cpu_io_pkg::*; #(
  parameter int n            = 32,
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [n-1:0] outport,
  input  logic         outport_we,
  output logic         tx,
  output logic         full,
  output logic         busy,
  output logic [7:0]   overflow_cnt
);

  localparam int BYTES  = bytes_per_word(n);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  tx_state_t         state_reg;
  logic [n-1:0]      word_reg;
  logic [BIDX_W-1:0] byte_idx_reg;
  logic [2:0]        bit_cnt_reg;
  logic [BAUD_W-1:0] baud_reg;
  logic              tx_reg;
  logic [7:0]        ovf_reg;

  logic [n-1:0]      fifo_dout;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic              baud_done, last_byte;

  outport_fifo #(.n(n), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (outport_we),
    .pop   (fifo_pop),
    .din   (outport),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    baud_done = (baud_reg == BAUD_W'(CLKS_PER_BIT - 1));
    last_byte = (byte_idx_reg == BIDX_W'(BYTES - 1));
    fifo_pop  = 1'b0;
    // Pop from IDLE, or straight out of the last STOP bit so words chain without a gap.
    if (state_reg == IDLE)
      fifo_pop = ~fifo_empty;
    else if (state_reg == STOP && baud_done && last_byte)
      fifo_pop = ~fifo_empty;
  end

  // word_reg shifts right per data bit, so the bit on the line is always word_reg[0].
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      word_reg     <= '0;
      byte_idx_reg <= '0;
      bit_cnt_reg  <= '0;
      baud_reg     <= '0;
      tx_reg       <= 1'b1;
    end else begin
      baud_reg <= baud_done ? '0 : baud_reg + 1'b1;
      case (state_reg)
        IDLE: begin
          baud_reg <= '0;
          tx_reg   <= 1'b1;
          if (fifo_pop) begin
            word_reg     <= fifo_dout;
            byte_idx_reg <= '0;
            bit_cnt_reg  <= '0;
            tx_reg       <= 1'b0;
            state_reg    <= START;
          end
        end
        START: begin
          if (baud_done) begin
            bit_cnt_reg <= '0;
            tx_reg      <= word_reg[0];
            state_reg   <= DATA;
          end
        end
        DATA: begin
          if (baud_done) begin
            word_reg <= word_reg >> 1;
            if (bit_cnt_reg == 3'd7) begin
              tx_reg    <= 1'b1;
              state_reg <= STOP;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
              tx_reg      <= word_reg[1];
            end
          end
        end
        STOP: begin
          if (baud_done) begin
            if (!last_byte) begin
              byte_idx_reg <= byte_idx_reg + 1'b1;
              tx_reg       <= 1'b0;
              state_reg    <= START;
            end else if (fifo_pop) begin
              word_reg     <= fifo_dout;
              byte_idx_reg <= '0;
              bit_cnt_reg  <= '0;
              tx_reg       <= 1'b0;
              state_reg    <= START;
            end else begin
              tx_reg    <= 1'b1;
              state_reg <= IDLE;
            end
          end
        end
        default: begin
          tx_reg    <= 1'b1;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      ovf_reg <= '0;
    else if (outport_we && fifo_full && ovf_reg != 8'hFF)
      ovf_reg <= ovf_reg + 1'b1;
  end

  assign tx           = tx_reg;
  assign full         = fifo_full;
  assign busy         = (state_reg != IDLE) | ~fifo_empty;
  assign overflow_cnt = ovf_reg;

endmodule

// File: tb/tb_outport_uart_tx.sv
// Directed bench for outport_uart_tx: a UART monitor decodes tx, the main sequence checks it.
module tb_outport_uart_tx;

  logic        clock;
  logic        reset;
  logic [31:0] outport;
  logic        outport_we;
  logic        tx;
  logic        full;
  logic        busy;
  logic [7:0]  overflow_cnt;

  int tests_run = 0;
  int tests_failed = 0;
  int busy_cnt = 0;

  typedef struct {
    logic [7:0] data;
    logic       framing_ok;
    int         gap;
  } rx_t;

  rx_t        rx_q[$];
  logic [7:0] mon_data;
  logic       mon_ok;
  int         mon_gap;
  int         mon_idle = 0;

  outport_uart_tx #(.n(32), .DEPTH(4), .CLKS_PER_BIT(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .outport      (outport),
    .outport_we   (outport_we),
    .tx           (tx),
    .full         (full),
    .busy         (busy),
    .overflow_cnt (overflow_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (busy === 1'b1) busy_cnt++;

  // Samples each bit mid-cell; gap counts idle-high samples since the previous stop sample.
  always begin
    @(negedge clock);
    if (reset === 1'b1 && tx === 1'b0) begin
      mon_gap = mon_idle;
      mon_ok  = 1'b1;
      repeat (2) @(negedge clock);
      if (tx !== 1'b0) mon_ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (4) @(negedge clock);
        mon_data[i] = tx;
      end
      repeat (4) @(negedge clock);
      if (tx !== 1'b1) mon_ok = 1'b0;
      rx_q.push_back('{mon_data, mon_ok, mon_gap});
      $display("[TB] rx byte %02h framing_ok=%0b gap=%0d", mon_data, mon_ok, mon_gap);
      mon_idle = 0;
    end else begin
      mon_idle++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_word(input logic [31:0] w);
    outport    = w;
    outport_we = 1'b1;
    $display("[TB] write %08h", w);
  endtask

  task automatic wait_rx(input int nbytes, input int max_cycles);
    int cnt = 0;
    while (rx_q.size() < nbytes && cnt < max_cycles) begin
      @(negedge clock);
      cnt++;
    end
    check("rx_wait", 32'(rx_q.size() >= nbytes), 32'd1);
  endtask

  task automatic expect_byte(input logic [7:0] exp, input int exp_gap);
    rx_t r;
    if (rx_q.size() == 0) begin
      check("rx_missing", 32'd0, 32'd1);
    end else begin
      r = rx_q.pop_front();
      check("rx_data", 32'(r.data), 32'(exp));
      check("rx_framing", 32'(r.framing_ok), 32'd1);
      if (exp_gap >= 0) check("rx_gap", 32'(r.gap), 32'(exp_gap));
    end
  endtask

  // first_contig: 1 when the word's first start bit must follow the previous stop bit directly.
  task automatic expect_word(input logic [31:0] w, input bit first_contig);
    logic [31:0] t;
    t = w;
    for (int b = 0; b < 4; b++) begin
      expect_byte(t[7:0], (b == 0 && !first_contig) ? -1 : 1);
      t = t >> 8;
    end
  endtask

  initial begin : main
    int b0;
    int low_cnt;

    reset      = 1'b0;
    outport    = '0;
    outport_we = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(overflow_cnt), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Single word: pop and start bit one edge after the write.
    b0 = busy_cnt;
    drive_word(32'h1234_5678);
    @(negedge clock);
    outport_we = 1'b0;
    check("single_tx_before_pop", 32'(tx), 32'd1);
    check("single_busy_early", 32'(busy), 32'd1);
    @(negedge clock);
    check("single_tx_fall", 32'(tx), 32'd0);
    wait_rx(4, 400);
    expect_word(32'h1234_5678, 1'b0);
    repeat (5) @(negedge clock);
    check("single_busy_low", 32'(busy), 32'd0);
    check("single_busy_cycles", 32'(busy_cnt - b0), 32'd161);

    // Back-to-back words chain with no idle bit between them.
    drive_word(32'hAAAA_AAAA);
    @(negedge clock);
    drive_word(32'h0000_00FF);
    @(negedge clock);
    outport_we = 1'b0;
    wait_rx(8, 800);
    expect_word(32'hAAAA_AAAA, 1'b0);
    expect_word(32'h0000_00FF, 1'b1);
    repeat (5) @(negedge clock);
    check("b2b_busy_low", 32'(busy), 32'd0);

    // Overflow: six writes, the sixth hits a full FIFO.
    for (int i = 1; i <= 6; i++) begin
      if (i == 5) check("ovf_full_before", 32'(full), 32'd0);
      if (i == 6) check("ovf_full_after5", 32'(full), 32'd1);
      drive_word(32'(i));
      @(negedge clock);
    end
    outport_we = 1'b0;
    check("ovf_cnt_one", 32'(overflow_cnt), 32'd1);
    wait_rx(20, 1200);
    for (int i = 1; i <= 5; i++) expect_word(32'(i), i != 1);
    repeat (10) @(negedge clock);
    check("ovf_rx_extra", 32'(rx_q.size()), 32'd0);
    check("ovf_busy_low", 32'(busy), 32'd0);
    check("ovf_full_low", 32'(full), 32'd0);

    // Saturation: hundreds of writes against a mostly full FIFO.
    for (int i = 0; i < 310; i++) begin
      outport    = 32'hDEAD_0000 + 32'(i);
      outport_we = 1'b1;
      @(negedge clock);
    end
    outport_we = 1'b0;
    $display("[TB] saturation burst done");
    check("sat_cnt", 32'(overflow_cnt), 32'd255);
    for (int i = 0; i < 20; i++) begin
      outport    = 32'hBEEF_0000 + 32'(i);
      outport_we = 1'b1;
      @(negedge clock);
    end
    outport_we = 1'b0;
    check("sat_hold", 32'(overflow_cnt), 32'd255);

    // Clean reset, then reset again in the middle of DATA bit 3.
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (60) @(negedge clock);
    rx_q.delete();
    check("clean_ovf_zero", 32'(overflow_cnt), 32'd0);
    drive_word(32'h1234_5670);
    @(negedge clock);
    drive_word(32'hCAFE_F00D);
    @(negedge clock);
    outport_we = 1'b0;
    repeat (17) @(negedge clock);
    check("mid_tx_bit3", 32'(tx), 32'd0);
    check("mid_busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_full", 32'(full), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (60) @(negedge clock);
    rx_q.delete();
    low_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (tx !== 1'b1) low_cnt++;
    end
    check("mid_no_residual_tx", 32'(low_cnt), 32'd0);
    check("mid_no_residual_rx", 32'(rx_q.size()), 32'd0);
    check("mid_busy_idle", 32'(busy), 32'd0);

    // Push and pop on the same edge with three words queued.
    drive_word(32'h0403_0201);
    @(negedge clock);
    drive_word(32'h0807_0605);
    @(negedge clock);
    drive_word(32'h0C0B_0A09);
    @(negedge clock);
    drive_word(32'h100F_0E0D);
    @(negedge clock);
    outport_we = 1'b0;
    check("pp_full_cnt3", 32'(full), 32'd0);
    repeat (157) @(negedge clock);
    drive_word(32'h1413_1211);
    check("pp_full_pre", 32'(full), 32'd0);
    @(negedge clock);
    drive_word(32'h1817_1615);
    check("pp_full_post", 32'(full), 32'd0);
    @(negedge clock);
    outport_we = 1'b0;
    check("pp_full_cnt4", 32'(full), 32'd1);
    wait_rx(24, 1400);
    expect_word(32'h0403_0201, 1'b0);
    expect_word(32'h0807_0605, 1'b1);
    expect_word(32'h0C0B_0A09, 1'b1);
    expect_word(32'h100F_0E0D, 1'b1);
    expect_word(32'h1413_1211, 1'b1);
    expect_word(32'h1817_1615, 1'b1);
    repeat (10) @(negedge clock);
    check("pp_busy_low", 32'(busy), 32'd0);
    check("pp_ovf_zero", 32'(overflow_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
